// File: rtl/sliced_add_sub.sv
// Multi-cycle adder/subtractor that processes SLICE bits per clock, LSB slice first.
// Results appear on S/COUT/OVF/ZERO only when the final slice completes.
module sliced_add_sub #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [SLICE-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic [WIDTH-1:0] slice_ext_s;
  logic [WIDTH-1:0] psum_next_s;
  logic             msb_cin_s;

  // Operands shift right each cycle, so the active slice is always the low SLICE bits.
  always_comb begin
    {slice_cout_s, slice_sum_s} = {1'b0, a_q[SLICE-1:0]} + {1'b0, bx_q[SLICE-1:0]}
                                  + {{SLICE{1'b0}}, carry_q};
    slice_ext_s                 = '0;
    slice_ext_s[SLICE-1:0]      = slice_sum_s;
    psum_next_s                 = (psum_q >> SLICE) | (slice_ext_s << (WIDTH - SLICE));
    // Carry into the slice MSB recovered from its sum bit; only meaningful on the last slice.
    msb_cin_s                   = slice_sum_s[SLICE-1] ^ a_q[SLICE-1] ^ bx_q[SLICE-1];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bx_d    = bx_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    psum_d  = psum_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          a_d     = A;
          bx_d    = SUB ? ~B : B;
          carry_d = CIN;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> SLICE;
        bx_d    = bx_q >> SLICE;
        carry_d = slice_cout_s;
        psum_d  = psum_next_s;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_CNT) begin
          s_d     = psum_next_s;
          cout_d  = slice_cout_s;
          ovf_d   = msb_cin_s ^ slice_cout_s;
          zero_d  = (psum_next_s == {WIDTH{1'b0}});
          state_d = ST_FIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_FIN);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      psum_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      psum_q  <= psum_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign S    = s_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;
  assign ZERO = zero_q;

endmodule
